// File: rtl/xs3_pkg.sv
// Shared Excess-3 constants and converter state encoding.
package xs3_pkg;
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/xs3_to_bin_seq_if.sv
// Handshake bundle between the XS-3 input stage, the converter and the binary datapath.
interface xs3_to_bin_seq_if #(parameter int DIGITS = 4) ();
    localparam int OUT_W = $clog2(10**DIGITS);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_xs3;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_bin;
    logic                  out_err;

    modport slave  (input  in_valid, in_xs3, out_ready,
                    output in_ready, out_valid, out_bin, out_err);
    modport master (output in_valid, in_xs3, out_ready,
                    input  in_ready, out_valid, out_bin, out_err);
endinterface

// File: rtl/xs3_digit_decode.sv
// Maps one XS-3 nibble to its decimal digit; illegal codes yield digit 0 with invalid_o set.
module xs3_digit_decode
    import xs3_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [3:0] digit_o,
    output logic       invalid_o
);
    always_comb begin
        invalid_o = (nibble_i < XS3_MIN) || (nibble_i > XS3_MAX);
        digit_o   = invalid_o ? 4'd0 : (nibble_i - XS3_OFFSET);
    end
endmodule

// File: rtl/xs3_to_bin_seq.sv
// Serial multi-digit XS-3 to binary converter: one digit per clock, acc = acc*10 + digit.
module xs3_to_bin_seq
    import xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    xs3_to_bin_seq_if.slave  bus
);
    localparam int OUT_W = $clog2(10**DIGITS);
    localparam int SUM_W = OUT_W + 4;
    localparam int IN_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q;
    logic [IN_W-1:0]    sr_q;
    logic [OUT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_bin_q;
    logic               out_err_q;

    logic [3:0]         digit;
    logic               invalid;
    logic [SUM_W-1:0]   acc_ext;
    logic [OUT_W-1:0]   acc_d;
    logic               err_d;

    xs3_digit_decode u_dec (
        .nibble_i  (sr_q[IN_W-1 -: 4]),
        .digit_o   (digit),
        .invalid_o (invalid)
    );

    // acc*10 as (acc<<3)+(acc<<1) in a widened sum; the result always fits back in OUT_W.
    always_comb begin
        acc_ext = {4'b0000, acc_q};
        acc_d   = OUT_W'((acc_ext << 3) + (acc_ext << 1) + SUM_W'(digit));
        err_d   = err_q | invalid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        sr_q       <= bus.in_xs3;
                        acc_q      <= '0;
                        err_q      <= 1'b0;
                        cnt_q      <= CNT_W'(DIGITS - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    acc_q <= acc_d;
                    err_q <= err_d;
                    sr_q  <= sr_q << 4;
                    if (cnt_q == '0) begin
                        out_bin_q   <= acc_d;
                        out_err_q   <= err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    // in_ready stays low this cycle so a word is never taken on the same edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_err   = out_err_q;
endmodule
